psum_drain_seq: RTL and testbench

//  Sequencer that drains the OFIFO into the psum SRAM, then optionally reads the stored psums back

---
 rtl/psum_drain_seq.sv | 97 +++++++++
 tb/tb_psum_drain_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/psum_drain_seq.sv
// Drives the OFIFO/pmem/acc fields of the core instruction bus: drains OFIFO rows into
// the psum SRAM, then optionally replays them through the SFP with accumulate asserted.
module psum_drain_seq #(
  parameter int addr_bw = 11,
  parameter int inst_bw = 34
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] num_vec,
  input  logic [addr_bw-1:0] wr_base,
  input  logic [addr_bw-1:0] rd_base,
  input  logic               acc_en,
  input  logic               ofifo_valid,
  output logic [inst_bw-1:0] inst_out,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] ACC   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [addr_bw-1:0] ONE = addr_bw'(1);

  logic [1:0]         state;
  logic [addr_bw-1:0] nv_q, wb_q, rb_q;
  logic               acc_q;
  logic [addr_bw-1:0] wcnt, rcnt;

  logic               pop, rd, acc;
  logic [addr_bw-1:0] a_pmem;

  // A zero-length job passes through DRAIN without touching the FIFO or SRAM.
  assign pop = (state == DRAIN) && ofifo_valid && (nv_q != '0);
  assign rd  = (state == ACC) && (rcnt != nv_q);
  // SRAM Q lags the read by one cycle, so acc trails the reads by one.
  assign acc = (state == ACC) && (rcnt != '0);

  always_comb begin
    a_pmem = '0;
    if (pop)     a_pmem = wb_q + wcnt;
    else if (rd) a_pmem = rb_q + rcnt;
  end

  always_comb begin
    inst_out        = '0;
    inst_out[33]    = acc;
    inst_out[32]    = ~(pop | rd);
    inst_out[31]    = ~pop;
    inst_out[30:20] = a_pmem;
    inst_out[19]    = 1'b1;
    inst_out[18]    = 1'b1;
    inst_out[6]     = pop;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      nv_q  <= '0;
      wb_q  <= '0;
      rb_q  <= '0;
      acc_q <= 1'b0;
      wcnt  <= '0;
      rcnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          nv_q  <= num_vec;
          wb_q  <= wr_base;
          rb_q  <= rd_base;
          acc_q <= acc_en;
          wcnt  <= '0;
          rcnt  <= '0;
          state <= DRAIN;
        end
        DRAIN: begin
          if (nv_q == '0) state <= DONE;
          else if (ofifo_valid) begin
            wcnt <= wcnt + ONE;
            if (wcnt == nv_q - ONE) state <= acc_q ? ACC : DONE;
          end
        end
        ACC: begin
          if (rcnt == nv_q) state <= DONE;
          else rcnt <= rcnt + ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain_seq.sv
// Randomized bench: each job is expanded into a cycle-by-cycle expected trace of
// inst_out/busy/done from the job description and the OFIFO valid pattern fed to the DUT.
module tb_psum_drain_seq;
  localparam int AW = 11;
  localparam int IW = 34;
  localparam logic [IW-1:0] IDLE_INST = 34'h1_800C_0000;

  logic          clk = 1'b0;
  logic          reset, start, acc_en, ofifo_valid;
  logic [AW-1:0] num_vec, wr_base, rd_base;
  logic [IW-1:0] inst_out;
  logic          busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            v;
    logic [IW-1:0] inst;
    bit            busy;
    bit            done;
  } exp_t;
  exp_t tr[$];

  always #5 clk = ~clk;

  psum_drain_seq #(.addr_bw(AW), .inst_bw(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec), .wr_base(wr_base),
    .rd_base(rd_base), .acc_en(acc_en), .ofifo_valid(ofifo_valid),
    .inst_out(inst_out), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_inst"}, inst_out, IDLE_INST);
    chk({tag, "_busy"}, {33'b0, busy}, '0);
    chk({tag, "_done"}, {33'b0, done}, '0);
  endtask

  function automatic logic [IW-1:0] mk(bit a, bit cen, bit wen, logic [AW-1:0] addr, bit pop);
    logic [IW-1:0] r;
    r = '0;
    r[33] = a; r[32] = cen; r[31] = wen; r[30:20] = addr;
    r[19] = 1'b1; r[18] = 1'b1; r[6] = pop;
    return r;
  endfunction

  task automatic push(input bit v, input logic [IW-1:0] i, input bit b, input bit d);
    exp_t e;
    e.v = v; e.inst = i; e.busy = b; e.done = d;
    tr.push_back(e);
  endtask

  // vmode: 0 random valid, 1 valid held high, 2 cycle through pat (bit 0 first)
  task automatic run_job(input int nv, input int wb, input int rb, input bit ae,
                         input int vmode, input logic [6:0] pat, input bit noise);
    int w, j;
    bit v;
    w = 0; j = 0;
    tr.delete();
    if (nv == 0) push(1'($urandom_range(0, 1)), IDLE_INST, 1, 0);
    while (w < nv) begin
      v = (vmode == 1) ? 1'b1 : (vmode == 2) ? pat[j % 7] : ($urandom_range(0, 9) < 6);
      j++;
      if (v) begin
        push(1, mk(0, 0, 0, AW'(wb + w), 1), 1, 0);
        w++;
      end else push(0, IDLE_INST, 1, 0);
    end
    if (ae && nv > 0)
      for (int k = 0; k <= nv; k++)
        push(1'($urandom_range(0, 1)), mk(k >= 1, k >= nv, 1, (k < nv) ? AW'(rb + k) : '0, 0), 1, 0);
    push(1'($urandom_range(0, 1)), IDLE_INST, 1, 1);
    push(0, IDLE_INST, 0, 0);

    @(posedge clk); #1;
    start = 1'b1; num_vec = AW'(nv); wr_base = AW'(wb); rd_base = AW'(rb); acc_en = ae;
    ofifo_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk_idle("start_cyc");
    foreach (tr[i]) begin
      @(posedge clk); #1;
      start = noise && tr[i].busy && ($urandom_range(0, 2) == 0);
      if (start) begin
        num_vec = AW'($urandom); wr_base = AW'($urandom); rd_base = AW'($urandom);
        acc_en = 1'($urandom);
      end
      ofifo_valid = tr[i].v;
      @(negedge clk);
      chk($sformatf("inst_c%0d", i), inst_out, tr[i].inst);
      chk($sformatf("busy_c%0d", i), {33'b0, busy}, {33'b0, tr[i].busy});
      chk($sformatf("done_c%0d", i), {33'b0, done}, {33'b0, tr[i].done});
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; acc_en = 1'b0; ofifo_valid = 1'b0;
    num_vec = '0; wr_base = '0; rd_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1 reset = 1'b1;

    run_job(4, 10, 0, 0, 1, 7'b0, 0);
    run_job(4, 10, 0, 0, 2, 7'b1011001, 0);
    run_job(3, 0, 2046, 1, 1, 7'b0, 0);
    run_job(0, 5, 5, 1, 0, 7'b0, 1);
    run_job(2, 2047, 2047, 1, 0, 7'b0, 1);

    // abort mid-DRAIN after two writes, then rerun from wr_base
    @(posedge clk); #1;
    start = 1'b1; num_vec = 11'd5; wr_base = 11'd100; rd_base = 11'd0; acc_en = 1'b1;
    ofifo_valid = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_pre", inst_out, mk(0, 0, 0, 11'd102, 1));
    #2 reset = 1'b0;
    #1 chk_idle("abort_async");
    repeat (3) begin
      @(negedge clk);
      chk_idle("abort_hold");
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk_idle("abort_rel");
    run_job(5, 100, 0, 1, 1, 7'b0, 0);

    for (int n = 0; n < 30; n++) begin
      int nv, wb, rb;
      nv = $urandom_range(0, 12);
      wb = ($urandom_range(0, 2) == 0) ? $urandom_range(2040, 2047) : $urandom_range(0, 2047);
      rb = ($urandom_range(0, 2) == 0) ? $urandom_range(2040, 2047) : $urandom_range(0, 2047);
      run_job(nv, wb, rb, 1'($urandom), 0, 7'b0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
